// File: rtl/flush_sequencer_if.sv
// Request-side handshake between commit/CSR and the flush sequencer.
interface flush_req_if #(parameter int NR_TARGETS = 14);
  logic                  req_valid_i;
  logic [NR_TARGETS-1:0] req_mask_i;
  logic                  req_set_pc_i;
  logic                  req_ready_o;

  modport master (output req_valid_i, req_mask_i, req_set_pc_i, input req_ready_o);
  modport slave  (input req_valid_i, req_mask_i, req_set_pc_i, output req_ready_o);
endinterface

// File: rtl/flush_sequencer.sv
// Flush controller: 1-cycle pulses for plain targets, held flush for acked targets.
// Optional forced abort of a stuck WAIT when FLUSH_TIMEOUT_EN is defined.
module flush_sequencer #(
  parameter int                    NR_TARGETS     = 14,
  parameter logic [NR_TARGETS-1:0] ACK_MASK       = 'h10,
  parameter int                    TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  flush_req_if.slave            req_if,
  input  logic                  mispredict_i,
  input  logic                  ex_i,
  input  logic [NR_TARGETS-1:0] ack_i,
  input  logic                  halt_csr_i,
  output logic [NR_TARGETS-1:0] flush_o,
  output logic                  set_pc_commit_o,
  output logic                  halt_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  timeout_o
);
  localparam logic [NR_TARGETS-1:0] MISP_MASK = NR_TARGETS'('h03);
  localparam logic [NR_TARGETS-1:0] EX_MASK   = NR_TARGETS'('h8F);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                r_state, w_state_d;
  logic [NR_TARGETS-1:0] r_pending, w_pending_d;
  logic [NR_TARGETS-1:0] w_flush;
  logic                  w_ready, w_accept, w_set_pc, w_done;

`ifdef FLUSH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] r_timer;
  logic          r_timed_out, w_timed_out_d;
`endif

  always_comb begin
    w_state_d   = r_state;
    w_pending_d = r_pending;
    w_flush     = '0;
    w_set_pc    = 1'b0;
    w_done      = 1'b0;
    w_ready     = (r_state == S_IDLE) & ~ex_i;
    w_accept    = req_if.req_valid_i & w_ready;
`ifdef FLUSH_TIMEOUT_EN
    w_timed_out_d = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_flush     = req_if.req_mask_i;
          w_set_pc    = req_if.req_set_pc_i;
          w_pending_d = req_if.req_mask_i & ACK_MASK;
          if (w_pending_d != '0) w_state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        w_flush     = r_pending;
        w_pending_d = r_pending & ~ack_i;
        if (w_pending_d == '0) begin
          w_state_d = S_DONE;
        end
`ifdef FLUSH_TIMEOUT_EN
        else if (r_timer == T_LAST) begin
          w_pending_d   = '0;
          w_state_d     = S_DONE;
          w_timed_out_d = 1'b1;
        end
`endif
      end
      S_DONE: begin
        w_done    = 1'b1;
        w_state_d = S_IDLE;
      end
      default: w_state_d = S_IDLE;
    endcase
    // Immediate flushes never touch the FSM; ex_i overrides any PC redirect.
    if (mispredict_i) w_flush = w_flush | MISP_MASK;
    if (ex_i) begin
      w_flush  = w_flush | EX_MASK;
      w_set_pc = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_d;
      r_pending <= w_pending_d;
    end
  end

`ifdef FLUSH_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_timer     <= '0;
      r_timed_out <= 1'b0;
    end else begin
      r_timed_out <= w_timed_out_d;
      if (r_state != S_WAIT) r_timer <= '0;
      else                   r_timer <= r_timer + 1'b1;
    end
  end
  assign timeout_o = (r_state == S_DONE) & r_timed_out;
`else
  assign timeout_o = 1'b0;
`endif

  assign req_if.req_ready_o = w_ready;
  assign flush_o            = w_flush;
  assign set_pc_commit_o    = w_set_pc;
  assign done_o             = w_done;
  assign halt_o             = halt_csr_i | (r_state == S_WAIT);
  assign busy_o             = (r_state != S_IDLE);
endmodule
